// File: rtl/shift_pipe.sv
// shift_pipe: 5-stage 32-bit right shift / rotate pipeline.
// Stages step by 16,8,4,2,1; global stall on output backpressure.
module shift_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic        sra,
  input  logic        rotate,
  input  logic [3:0]  in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  out_tag,
  output logic [2:0]  inflight
);

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [3:0]  tag;
    logic        sra;
    logic        rot;
    logic        sgn;
    logic [4:0]  sh;
  } stage_t;

  stage_t st [5];
  stage_t src [5];

  logic stall;
  logic adv;
  logic acc;
  logic ret;

  function automatic logic [31:0] step(
    input logic [31:0] d,
    input logic [5:0]  n,
    input logic        rot,
    input logic        fill
  );
    logic [31:0] hi;
    hi = rot ? d : {32{fill}};
    return (d >> n) | (hi << (6'd32 - n));
  endfunction

  assign stall     = st[4].v && !out_ready;
  assign adv       = !stall;
  assign in_ready  = adv;
  assign acc       = in_valid && in_ready;
  assign ret       = st[4].v && out_ready;
  assign out_valid = st[4].v;
  assign result    = st[4].d;
  assign out_tag   = st[4].tag;

  always_comb begin
    src[0]     = '0;
    src[0].v   = acc;
    src[0].d   = a;
    src[0].tag = in_tag;
    src[0].sra = sra;
    src[0].rot = rotate;
    src[0].sgn = a[31];
    src[0].sh  = shamt;
    for (int i = 1; i < 5; i++) begin
      src[i] = st[i-1];
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam logic [5:0] N = 6'd16 >> i;
    stage_t nx;

    // sign fill comes from the operand's original MSB
    always_comb begin
      nx = src[i];
      if (src[i].sh[4-i]) begin
        nx.d = step(src[i].d, N, src[i].rot,
                    src[i].sra & src[i].sgn);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st[i] <= '0;
      end else if (adv) begin
        st[i] <= nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (acc && !ret) begin
      inflight <= inflight + 3'd1;
    end else if (ret && !acc) begin
      inflight <= inflight - 3'd1;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed table, stall/reset sequences
// and randomized traffic against a bit-serial reference.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        sra;
  logic        rotate;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic [2:0]  inflight;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .sra       (sra),
    .rotate    (rotate),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .inflight  (inflight)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic        sra;
    logic        rot;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  t;
  } exp_t;

  vec_t vec [12];
  exp_t q [$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] refsh(
    input logic [31:0] x, input logic [4:0] s,
    input logic sr, input logic rt);
    logic [31:0] r;
    r = x;
    if (rt) begin
      for (int k = 0; k < 32; k++)
        if (k < int'(s)) r = {r[0], r[31:1]};
    end else if (sr) begin
      r = $signed(x) >>> s;
    end else begin
      r = x >> s;
    end
    return r;
  endfunction

  task automatic drive(input logic [31:0] va, input logic [4:0] vs,
                       input logic vsr, input logic vrt,
                       input logic [3:0] vt);
    a = va; shamt = vs; sra = vsr; rotate = vrt; in_tag = vt;
    in_valid = 1'b1;
  endtask

  int   cnt;
  bit   acc;
  bit   seen;
  exp_t e;

  initial begin
    vec[0]  = '{32'h12345678, 5'd4,  1'b0, 1'b0, 4'd1, 32'h01234567};
    vec[1]  = '{32'h87654321, 5'd16, 1'b1, 1'b0, 4'd2, 32'hFFFF8765};
    vec[2]  = '{32'h87654321, 5'd16, 1'b0, 1'b0, 4'd3, 32'h00008765};
    vec[3]  = '{32'hFEDCBA98, 5'd8,  1'b1, 1'b1, 4'd4, 32'h98FEDCBA};
    vec[4]  = '{32'hC0FFEE01, 5'd0,  1'b1, 1'b0, 4'd5, 32'hC0FFEE01};
    vec[5]  = '{32'h80000000, 5'd31, 1'b1, 1'b0, 4'd6, 32'hFFFFFFFF};
    vec[6]  = '{32'h80000000, 5'd31, 1'b0, 1'b0, 4'd7, 32'h00000001};
    vec[7]  = '{32'h00000001, 5'd1,  1'b0, 1'b1, 4'd8, 32'h80000000};
    vec[8]  = '{32'hF0000001, 5'd1,  1'b1, 1'b0, 4'd9, 32'hF8000000};
    vec[9]  = '{32'h12345678, 5'd31, 1'b0, 1'b1, 4'hA, 32'h2468ACF0};
    vec[10] = '{32'hA5A5A5A5, 5'd5,  1'b0, 1'b0, 4'hB, 32'h052D2D2D};
    vec[11] = '{32'hA5A5A5A5, 5'd5,  1'b1, 1'b0, 4'hC, 32'hFD2D2D2D};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; shamt = '0; sra = 1'b0; rotate = 1'b0; in_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inflight", {29'b0, inflight}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", {28'b0, out_tag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      drive(vec[i].a, vec[i].sh, vec[i].sra, vec[i].rot, vec[i].tag);
      @(negedge clk);
      in_valid = 1'b0;
      cnt = 1;
      while (!out_valid && cnt < 12) begin
        @(negedge clk);
        cnt++;
      end
      chk($sformatf("latency%0d", i), cnt, 32'd5);
      chk($sformatf("result%0d", i), result, vec[i].exp);
      chk($sformatf("tag%0d", i), {28'b0, out_tag}, {28'b0, vec[i].tag});
      @(negedge clk);
    end

    for (int t = 0; t < 5; t++) begin
      drive(32'h11111111 * t + 32'h80000000, 5'(t * 3), 1'b1, 1'b0, 4'(t));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_tag", {28'b0, out_tag}, 32'd0);
      chk("stall_result", result, refsh(32'h80000000, 5'd0, 1'b1, 1'b0));
      chk("stall_inflight", {29'b0, inflight}, 32'd5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      chk("drain_valid", {31'b0, out_valid}, 32'd1);
      chk("drain_tag", {28'b0, out_tag}, t);
      chk("drain_result", result,
          refsh(32'h11111111 * t + 32'h80000000, 5'(t * 3), 1'b1, 1'b0));
      @(negedge clk);
    end
    chk("drain_empty", {31'b0, out_valid}, 32'd0);
    chk("drain_inflight", {29'b0, inflight}, 32'd0);

    for (int t = 0; t < 3; t++) begin
      drive(32'hDEADBEEF, 5'd3, 1'b0, 1'b0, 4'(t + 4));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_inflight", {29'b0, inflight}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_output", {31'b0, seen}, 32'd0);

    acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c < 500) begin
        if (acc) begin in_valid = 1'b0; acc = 1'b0; end
        if (!in_valid && $urandom_range(0, 3) != 0)
          drive($urandom, 5'($urandom_range(0, 31)), 1'($urandom),
                1'($urandom), 4'($urandom));
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      chk("rnd_inflight", {29'b0, inflight}, q.size());
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_result", result, e.r);
          chk("rnd_tag", {28'b0, out_tag}, {28'b0, e.t});
        end
      end
      if (in_valid && in_ready) begin
        e.r = refsh(a, shamt, sra, rotate);
        e.t = in_tag;
        q.push_back(e);
        acc = 1'b1;
      end
    end
    chk("rnd_all_drained", q.size(), 32'd0);
    chk("rnd_final_inflight", {29'b0, inflight}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameters SHALL be none; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a  input  32  operand.
REQ-007 shamt  input  5  right-shift/rotate amount, 0..31.
REQ-008 sra  input  1  arithmetic right shift (sign fill) when rotate=0.
REQ-009 rotate  input  1  rotate right; overrides sra.
REQ-010 in_tag  input  4  opaque tag carried with request.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 result  output  32  shifted/rotated operand.
REQ-014 out_tag  output  4  tag of the request producing result.
REQ-015 inflight  output  3  count of valid entries in pipe, 0..5.

Function
REQ-016 Pipe SHALL have 5 registered stages S1..S5 applying conditional steps of 16, 8, 4, 2, 1 controlled by shamt[4], [3], [2], [1], [0] respectively.
REQ-017 Each stage SHALL register data, valid bit, tag, sra, rotate and remaining shamt bits.
REQ-018 Step mode: rotate=1 -> bits leaving LSB re-enter at MSB; rotate=0, sra=1 -> vacated MSBs filled with original a[31]; both 0 -> zero fill.
REQ-019 Sign fill SHALL use the sign bit captured at S1 entry, not the partially shifted value.
REQ-020 A stage whose shamt bit is 0 SHALL pass data unchanged; shamt=0 returns a unchanged.
REQ-021 Accept occurs when in_valid && in_ready; latency from accept to out_valid SHALL be exactly 5 cycles with no stall.
REQ-022 Stall = out_valid && !out_ready; on stall every stage SHALL hold its contents (global stall).
REQ-023 in_ready SHALL equal !stall, combinationally.
REQ-024 Without stall, the pipe SHALL advance every cycle; a cycle with no accept inserts a bubble (valid=0) into S1.
REQ-025 result, out_tag, out_valid SHALL be driven directly from S5 registers; result and tag SHALL remain stable while out_valid && !out_ready.
REQ-026 Throughput SHALL be one request per cycle when out_ready stays high; results SHALL emerge in accept order.
REQ-027 inflight SHALL equal the number of set valid bits in S1..S5 as registered state, updated +1 on accept-without-retire, -1 on retire-without-accept, unchanged when both or neither occur.
REQ-028 Retire = out_valid && out_ready.
REQ-029 in_valid while in_ready=0 SHALL be ignored; upstream holds its request.
REQ-030 Data-path values of bubble stages are don't-care but out_valid SHALL be 0 for them.

Reset
REQ-031 When rst_n=0 at a rising edge, all stage valid bits SHALL clear, inflight SHALL become 0, result and out_tag SHALL become 0.
REQ-032 Reset SHALL take priority over accept and stall; requests in flight are discarded with no output.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 a=0x12345678, shamt=4, sra=0, rotate=0, tag=1 -> after 5 cycles result=0x01234567, out_tag=1.
REQ-035 a=0x87654321, shamt=16, sra=1 -> result=0xFFFF8765; same with sra=0 -> 0x00008765.
REQ-036 a=0xFEDCBA98, shamt=8, rotate=1, sra=1 -> result=0x98FEDCBA; shamt=0 on 0xC0FFEE01 -> 0xC0FFEE01.
REQ-037 Five back-to-back accepts tags 0..4, out_ready low 3 cycles once tag0 valid -> in_ready=0, result/tag held, inflight=5; after release tags 0..4 emerge on consecutive cycles, inflight returns to 0.
REQ-038 Accept 3 requests, assert rst_n=0 for one cycle mid-flight -> out_valid never asserts for them, inflight=0, result=0.
REQ-039 Random stimulus with random out_ready -> every result matches reference model, in order, no drops or duplicates.
